// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared constants and action decode for the pipeline stage register
package pipe_stage_reg_pkg;

   localparam logic        Stop         = 1'b1;
   localparam logic        NoStop       = 1'b0;
   localparam logic        WriteDisable = 1'b0;
   localparam int unsigned NOPRegAddr   = 0;
   localparam int unsigned ZeroWord     = 0;

   typedef enum logic [1:0] {
      ACT_HOLD    = 2'd0,
      ACT_ADVANCE = 2'd1,
      ACT_BUBBLE  = 2'd2,
      ACT_FLUSH   = 2'd3
   } stage_act_t;

   // Reset is handled by the callers; this only orders flush > bubble > advance > hold.
   function automatic stage_act_t stage_act(input logic flush,
                                            input logic stall_here,
                                            input logic stall_next);
      stage_act_t act;
      if (flush)
         act = ACT_FLUSH;
      else if (stall_here == Stop && stall_next == NoStop)
         act = ACT_BUBBLE;
      else if (stall_here == NoStop)
         act = ACT_ADVANCE;
      else
         act = ACT_HOLD;
      return act;
   endfunction

endpackage

// File: rtl/pipe_chan_reg.sv
// rtl/pipe_chan_reg.sv - one register-write channel (address, enable, data) of the stage register
module pipe_chan_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          stall_here,
   input  logic          stall_next,
   input  logic          mem_valid,
   input  logic [AW-1:0] mem_wd,
   input  logic          mem_wreg,
   input  logic [DW-1:0] mem_wdata,
   output logic [AW-1:0] wb_wd,
   output logic          wb_wreg,
   output logic [DW-1:0] wb_wdata
);

   stage_act_t act;

   assign act = stage_act(flush, stall_here, stall_next);

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_wd    <= AW'(NOPRegAddr);
         wb_wreg  <= WriteDisable;
         wb_wdata <= DW'(ZeroWord);
      end else begin
         case (act)
            ACT_FLUSH, ACT_BUBBLE: begin
               wb_wd    <= AW'(NOPRegAddr);
               wb_wreg  <= WriteDisable;
               wb_wdata <= DW'(ZeroWord);
            end
            ACT_ADVANCE: begin
               // Address and data pass even for an empty slot; only the enable is gated.
               wb_wd    <= mem_wd;
               wb_wreg  <= mem_wreg & mem_valid;
               wb_wdata <= mem_wdata;
            end
            default: begin
               wb_wd    <= wb_wd;
               wb_wreg  <= wb_wreg;
               wb_wdata <= wb_wdata;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - registered pipeline stage with stall/flush, HI/LO channel and retire counter
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int DW      = 32,
   parameter int AW      = 5,
   parameter int NCH     = 1,
   parameter int STAGE   = 4,
   parameter int SW      = 6,
   parameter bit HILO_EN = 1'b1,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SW-1:0]      stall,
   input  logic               flush,
   input  logic               mem_valid,
   input  logic [NCH*AW-1:0]  mem_wd,
   input  logic [NCH-1:0]     mem_wreg,
   input  logic [NCH*DW-1:0]  mem_wdata,
   input  logic [DW-1:0]      mem_hi,
   input  logic [DW-1:0]      mem_lo,
   input  logic               mem_whilo,
   output logic               wb_valid,
   output logic [NCH*AW-1:0]  wb_wd,
   output logic [NCH-1:0]     wb_wreg,
   output logic [NCH*DW-1:0]  wb_wdata,
   output logic [DW-1:0]      wb_hi,
   output logic [DW-1:0]      wb_lo,
   output logic               wb_whilo,
   output logic [CNT_W-1:0]   retire_cnt
);

   logic       stall_here;
   logic       stall_next;
   stage_act_t act;

   assign stall_here = stall[STAGE];

   // The last stage has no downstream stage, so it always sees NoStop below it.
   generate
      if (STAGE < SW-1) begin : g_mid_stage
         assign stall_next = stall[STAGE+1];
      end else begin : g_last_stage
         assign stall_next = NoStop;
      end
   endgenerate

   wire unused_stall_bits = ^stall;

   assign act = stage_act(flush, stall_here, stall_next);

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
         pipe_chan_reg #(
            .DW (DW),
            .AW (AW)
         ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .stall_here (stall_here),
            .stall_next (stall_next),
            .mem_valid  (mem_valid),
            .mem_wd     (mem_wd[gi*AW +: AW]),
            .mem_wreg   (mem_wreg[gi]),
            .mem_wdata  (mem_wdata[gi*DW +: DW]),
            .wb_wd      (wb_wd[gi*AW +: AW]),
            .wb_wreg    (wb_wreg[gi]),
            .wb_wdata   (wb_wdata[gi*DW +: DW])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid   <= 1'b0;
         retire_cnt <= '0;
      end else begin
         case (act)
            ACT_FLUSH, ACT_BUBBLE: begin
               wb_valid <= 1'b0;
            end
            ACT_ADVANCE: begin
               wb_valid <= mem_valid;
               if (mem_valid)
                  retire_cnt <= retire_cnt + CNT_W'(1);
            end
            default: begin
               wb_valid <= wb_valid;
            end
         endcase
      end
   end

   generate
      if (HILO_EN) begin : g_hilo
         always_ff @(posedge clk) begin
            if (rst) begin
               wb_hi    <= DW'(ZeroWord);
               wb_lo    <= DW'(ZeroWord);
               wb_whilo <= WriteDisable;
            end else begin
               case (act)
                  ACT_FLUSH, ACT_BUBBLE: begin
                     wb_hi    <= DW'(ZeroWord);
                     wb_lo    <= DW'(ZeroWord);
                     wb_whilo <= WriteDisable;
                  end
                  ACT_ADVANCE: begin
                     wb_hi    <= mem_hi;
                     wb_lo    <= mem_lo;
                     wb_whilo <= mem_whilo & mem_valid;
                  end
                  default: begin
                     wb_hi    <= wb_hi;
                     wb_lo    <= wb_lo;
                     wb_whilo <= wb_whilo;
                  end
               endcase
            end
         end
      end else begin : g_no_hilo
         assign wb_hi    = DW'(ZeroWord);
         assign wb_lo    = DW'(ZeroWord);
         assign wb_whilo = WriteDisable;
         wire unused_hilo_inputs = ^{mem_hi, mem_lo, mem_whilo};
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic        mem_valid;
   logic [9:0]  mem_wd;
   logic [1:0]  mem_wreg;
   logic [63:0] mem_wdata;
   logic [31:0] mem_hi;
   logic [31:0] mem_lo;
   logic        mem_whilo;

   logic        wb_valid,  w_valid,  e_valid;
   logic [9:0]  wb_wd,     w_wd,     e_wd;
   logic [1:0]  wb_wreg,   w_wreg,   e_wreg;
   logic [63:0] wb_wdata,  w_wdata,  e_wdata;
   logic [31:0] wb_hi,     w_hi,     e_hi;
   logic [31:0] wb_lo,     w_lo,     e_lo;
   logic        wb_whilo,  w_whilo,  e_whilo;
   logic [31:0] retire_cnt, e_cnt;
   logic [3:0]  w_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   wire [141:0] obs   = {wb_valid, wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo};
   wire [64:0]  w_hl  = {w_hi, w_lo, w_whilo};

   always #5 clk = ~clk;

   pipe_stage_reg #(.NCH(2)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
      .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
      .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo), .retire_cnt(retire_cnt)
   );

   pipe_stage_reg #(.NCH(2), .CNT_W(4), .HILO_EN(1'b0)) dut_w (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
      .wb_valid(w_valid), .wb_wd(w_wd), .wb_wreg(w_wreg), .wb_wdata(w_wdata),
      .wb_hi(w_hi), .wb_lo(w_lo), .wb_whilo(w_whilo), .retire_cnt(w_cnt)
   );

   // Last-stage instance: stall[STAGE+1] does not exist and must read as NoStop.
   pipe_stage_reg #(.NCH(2), .STAGE(5)) dut_e (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
      .wb_valid(e_valid), .wb_wd(e_wd), .wb_wreg(e_wreg), .wb_wdata(e_wdata),
      .wb_hi(e_hi), .wb_lo(e_lo), .wb_whilo(e_whilo), .retire_cnt(e_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [9:0] wd, input logic [1:0] wr,
                        input logic [63:0] wdat, input logic [31:0] hi,
                        input logic [31:0] lo, input logic whl);
      mem_valid = v; mem_wd = wd; mem_wreg = wr; mem_wdata = wdat;
      mem_hi = hi; mem_lo = lo; mem_whilo = whl;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; stall = 6'b0;
      drive(1'b1, 10'h3FF, 2'b11, 64'hFFFF_0000_1234_5678, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);
      tick();
      tick();
      n_cmp++;
      if (obs !== 142'd0) begin
         n_fail++; $display("FAIL reset_outputs: got %h expected 0", obs);
      end
      n_cmp++;
      if (retire_cnt !== 32'd0 || w_cnt !== 4'd0) begin
         n_fail++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", retire_cnt, w_cnt);
      end
   endtask

   task automatic test_advance();
      rst = 1'b0; stall = 6'b0; flush = 1'b0;
      drive(1'b1, {5'd3, 5'd7}, 2'b11, {32'hA, 32'hB}, 32'h1111_1111, 32'h2222_2222, 1'b1);
      tick();
      n_cmp++;
      if (obs !== {1'b1, 5'd3, 5'd7, 2'b11, 32'hA, 32'hB, 32'h1111_1111, 32'h2222_2222, 1'b1}) begin
         n_fail++; $display("FAIL advance_outputs: got %h", obs);
      end
      n_cmp++;
      if (retire_cnt !== 32'd1 || w_cnt !== 4'd1) begin
         n_fail++; $display("FAIL advance_cnt: got %0d/%0d expected 1/1", retire_cnt, w_cnt);
      end
      n_cmp++;
      if (w_hl !== 65'd0) begin
         n_fail++; $display("FAIL hilo_disabled_adv: got %h expected 0", w_hl);
      end
   endtask

   task automatic test_bubble_hold();
      // stall[5] only: stage 4 advances, the last stage bubbles.
      stall = 6'b100000;
      drive(1'b1, {5'd9, 5'd12}, 2'b01, {32'hC, 32'hD}, 32'h3333_3333, 32'h4444_4444, 1'b0);
      tick();
      n_cmp++;
      if (obs !== {1'b1, 5'd9, 5'd12, 2'b01, 32'hC, 32'hD, 32'h3333_3333, 32'h4444_4444, 1'b0}) begin
         n_fail++; $display("FAIL downstream_stall_advance: got %h", obs);
      end
      n_cmp++;
      if (e_valid !== 1'b0 || e_wreg !== 2'b00 || e_cnt !== 32'd1) begin
         n_fail++; $display("FAIL last_stage_bubble: got v=%b wreg=%b cnt=%0d expected 0 00 1", e_valid, e_wreg, e_cnt);
      end

      stall = 6'b011111;
      tick();
      n_cmp++;
      if (obs !== 142'd0 || retire_cnt !== 32'd2) begin
         n_fail++; $display("FAIL bubble: got %h cnt=%0d expected 0 cnt=2", obs, retire_cnt);
      end
      n_cmp++;
      if (e_valid !== 1'b1 || e_cnt !== 32'd2) begin
         n_fail++; $display("FAIL last_stage_advance: got v=%b cnt=%0d expected 1 2", e_valid, e_cnt);
      end

      stall = 6'b000000;
      drive(1'b1, {5'd1, 5'd2}, 2'b10, {32'hE, 32'hF}, 32'h5555_5555, 32'h6666_6666, 1'b1);
      tick();
      stall = 6'b111111;
      drive(1'b1, {5'd31, 5'd30}, 2'b11, {32'h99, 32'h98}, 32'h7777_7777, 32'h8888_8888, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (obs !== {1'b1, 5'd1, 5'd2, 2'b10, 32'hE, 32'hF, 32'h5555_5555, 32'h6666_6666, 1'b1}
             || retire_cnt !== 32'd3) begin
            n_fail++; $display("FAIL hold_cycle%0d: got %h cnt=%0d expected cnt=3", i, obs, retire_cnt);
         end
      end
   endtask

   task automatic test_flush();
      stall = 6'b0; flush = 1'b1;
      drive(1'b1, {5'd5, 5'd6}, 2'b11, {32'h1, 32'h2}, 32'h1, 32'h2, 1'b1);
      tick();
      n_cmp++;
      if (obs !== 142'd0 || retire_cnt !== 32'd3) begin
         n_fail++; $display("FAIL flush_no_stall: got %h cnt=%0d expected 0 cnt=3", obs, retire_cnt);
      end
      flush = 1'b0;
      tick();
      stall = 6'b111111; flush = 1'b1;
      tick();
      n_cmp++;
      if (obs !== 142'd0 || retire_cnt !== 32'd4) begin
         n_fail++; $display("FAIL flush_over_hold: got %h cnt=%0d expected 0 cnt=4", obs, retire_cnt);
      end
      flush = 1'b0;
   endtask

   task automatic test_invalid_slot();
      stall = 6'b0;
      drive(1'b0, {5'd4, 5'd5}, 2'b11, {32'h10, 32'h20}, 32'h77, 32'h88, 1'b1);
      tick();
      n_cmp++;
      if (obs !== {1'b0, 5'd4, 5'd5, 2'b00, 32'h10, 32'h20, 32'h77, 32'h88, 1'b0}
          || retire_cnt !== 32'd4) begin
         n_fail++; $display("FAIL invalid_slot: got %h cnt=%0d expected cnt=4", obs, retire_cnt);
      end
   endtask

   task automatic test_reset_mid_stall();
      stall = 6'b0;
      drive(1'b1, {5'd8, 5'd8}, 2'b11, {32'h5, 32'h5}, 32'h9, 32'h9, 1'b1);
      tick();
      stall = 6'b111111; flush = 1'b1; rst = 1'b1;
      tick();
      n_cmp++;
      if (obs !== 142'd0 || retire_cnt !== 32'd0) begin
         n_fail++; $display("FAIL reset_over_stall: got %h cnt=%0d expected 0 cnt=0", obs, retire_cnt);
      end
      rst = 1'b0; flush = 1'b0;
      tick();
      n_cmp++;
      if (obs !== 142'd0 || retire_cnt !== 32'd0) begin
         n_fail++; $display("FAIL hold_after_reset: got %h cnt=%0d expected 0 cnt=0", obs, retire_cnt);
      end
   endtask

   task automatic test_wrap();
      rst = 1'b1; stall = 6'b0; flush = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, {5'(i), 5'(i)}, 2'b11, {32'(i), 32'(i + 1)}, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
         tick();
         n_cmp++;
         if (w_hl !== 65'd0) begin
            n_fail++; $display("FAIL hilo_disabled_%0d: got %h expected 0", i, w_hl);
         end
      end
      n_cmp++;
      if (w_cnt !== 4'd1) begin
         n_fail++; $display("FAIL wrap_cnt4: got %0d expected 1", w_cnt);
      end
      n_cmp++;
      if (retire_cnt !== 32'd17) begin
         n_fail++; $display("FAIL cnt32_17: got %0d expected 17", retire_cnt);
      end
      n_cmp++;
      if ({w_wd, w_wreg, w_wdata} !== {5'd16, 5'd16, 2'b11, 32'd16, 32'd17}) begin
         n_fail++; $display("FAIL hilo_off_channels: got %h", {w_wd, w_wreg, w_wdata});
      end
   endtask

   initial begin
      test_reset();
      test_advance();
      test_bubble_hold();
      test_flush();
      test_invalid_slot();
      test_reset_mid_stall();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL run on one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-002 Parameters (name, default, meaning) SHALL be:
- DW, 32, data width.
- AW, 5, register-address width.
- NCH, 1, number of register write channels.
- STAGE, 4, this stage's index into the stall vector.
- SW, 6, stall vector width.
- HILO_EN, 1, enables the HI/LO channel.
- CNT_W, 32, retire counter width.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- stall, in, SW, per-stage stall vector (1 = Stop).
- flush, in, 1, discards the incoming instruction.
- mem_valid, in, 1, upstream slot holds a real instruction.
- mem_wd, in, NCH*AW, destination addresses; channel i at bits [i*AW +: AW].
- mem_wreg, in, NCH, write enables.
- mem_wdata, in, NCH*DW, write data; channel i at bits [i*DW +: DW].
- mem_hi, in, DW, HI data.
- mem_lo, in, DW, LO data.
- mem_whilo, in, 1, HI/LO write enable.
- wb_valid, out, 1, registered valid.
- wb_wd, out, NCH*AW, registered addresses.
- wb_wreg, out, NCH, registered enables.
- wb_wdata, out, NCH*DW, registered data.
- wb_hi, out, DW, registered HI.
- wb_lo, out, DW, registered LO.
- wb_whilo, out, 1, registered HI/LO enable.
- retire_cnt, out, CNT_W, count of valid instructions passed downstream.

Function
REQ-004 All outputs SHALL be registered; latency from input to output is 1 clk.
REQ-005 Per-edge action priority SHALL be: rst > flush > bubble > advance > hold.
REQ-006 Bubble SHALL occur when stall[STAGE]=1 and stall[STAGE+1]=0; when STAGE=SW-1, stall[STAGE+1] is taken as 0.
REQ-007 Flush or bubble SHALL load: wb_valid=0, wb_wd=0, wb_wreg=0, wb_wdata=0, wb_hi=0, wb_lo=0, wb_whilo=0; retire_cnt SHALL be unchanged.
REQ-008 Advance (stall[STAGE]=0) SHALL load:
- wb_valid=mem_valid.
- wb_wd=mem_wd.
- wb_wdata=mem_wdata.
- wb_hi=mem_hi; wb_lo=mem_lo.
- wb_wreg[i]=mem_wreg[i] AND mem_valid.
- wb_whilo=mem_whilo AND mem_valid.
REQ-009 Hold (stall[STAGE]=1 and stall[STAGE+1]=1) SHALL keep every output, including retire_cnt, unchanged.
REQ-010 retire_cnt SHALL increment by 1 only on advance with mem_valid=1, and wrap modulo 2^CNT_W with no saturation.
REQ-011 When HILO_EN=0, wb_hi, wb_lo and wb_whilo SHALL be constant 0.
REQ-012 Channels SHALL be independent; identical addresses on two channels pass through unchanged (conflict resolution belongs to the register file).
REQ-013 flush asserted together with any stall pattern SHALL produce the flush result.

Reset
REQ-014 On rst=1 at a clk edge, all outputs SHALL be 0, including retire_cnt.
REQ-015 Reset mid-stall or mid-flush SHALL override both; the first non-reset edge then follows REQ-005.

Structure
REQ-016 A shared package SHALL hold Stop=1, NoStop=0, NOPRegAddr=0, ZeroWord=0 and WriteDisable=0.
REQ-017 One sub-module, pipe_chan_reg (a single address/enable/data channel implementing REQ-005 to REQ-009), SHALL be instantiated NCH times.
REQ-018 HI/LO and counter logic SHALL live in the top module.

Verification
REQ-019 Reset: rst=1 for 2 clk with mem inputs non-zero -> all outputs 0, retire_cnt=0.
REQ-020 Advance: NCH=2, mem_valid=1, mem_wd={5'd3,5'd7}, mem_wreg=2'b11, mem_wdata={32'hA,32'hB}, stall=0 -> the next clk shows the same values, wb_valid=1, retire_cnt=1.
REQ-021 Bubble vs hold:
- stall=6'b011111 -> outputs cleared, retire_cnt unchanged.
- stall=6'b111111 for 3 clk -> previous outputs held for all 3 clk.
REQ-022 Flush priority: flush=1 with stall=0 and mem_valid=1 -> wb_valid=0, wb_wreg=0, retire_cnt unchanged.
REQ-023 Invalid slot: mem_valid=0, mem_wreg=1, mem_whilo=1 -> wb_wreg=0, wb_whilo=0, data passed through, no count.
REQ-024 Wrap: CNT_W=4, 17 valid advances -> retire_cnt=1; HILO_EN=0 -> wb_hi, wb_lo and wb_whilo stay 0 throughout.
